// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the instruction/data RAM arbiter
package mem_arb_pkg;
  localparam int OWN_W = 2;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_WAIT_DEF = 4;
  typedef enum logic [OWN_W-1:0] {OWN_IDLE, OWN_RD_I, OWN_RD_D} owner_t;
endpackage

// File: rtl/mem_arb_age_cnt.sv
// mem_arb_age_cnt: saturating count of consecutive I-port losses (exists only with STARVE_GUARD_EN)
//  clk, reset (async, active-low); inc: I lost to D this cycle; clr: I granted or not requesting;
//  sat: count reached MAX_WAIT, I-port must win next arbitration.
`ifdef STARVE_GUARD_EN
module mem_arb_age_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  assign sat = cnt == CW'(MAX_WAIT);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + 1'b1;
endmodule
`endif

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port sync RAM between fetch (I, read-only) and memory (D) stages
//  clk, reset (async, active-low)
//  I-port: i_req, i_addr -> i_gnt, i_stall, i_rvalid, i_rdata
//  D-port: d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//  RAM:    mem_cs, mem_oe, mem_we, mem_addr, mem_din -> ; mem_dout <- (1-cycle read latency)
//  `STARVE_GUARD_EN: after MAX_WAIT consecutive losses the I-port wins one cycle over D.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  owner_t owner;
  logic force_i;
  logic [DATA_W-1:0] i_hold, d_hold;
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT must be at least 1");
  end
`ifdef STARVE_GUARD_EN
  mem_arb_age_cnt #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk(clk),
    .reset(reset),
    .inc(i_req & d_req & ~i_gnt),
    .clr(~i_req | i_gnt),
    .sat(force_i)
  );
`else
  assign force_i = 1'b0;
`endif
  // Grants are gated by reset so the RAM sees no strobes while reset is held.
  assign d_gnt = reset & d_req & ~force_i;
  assign i_gnt = reset & i_req & (~d_req | force_i);
  assign i_stall = reset & i_req & ~i_gnt;
  assign mem_cs = i_gnt | d_gnt;
  assign mem_we = d_gnt & d_we;
  assign mem_oe = i_gnt | (d_gnt & ~d_we);
  assign mem_addr = i_gnt ? i_addr : d_gnt ? d_addr : '0;
  assign mem_din = mem_we ? d_wdata : '0;
  assign i_rvalid = owner == OWN_RD_I;
  assign d_rvalid = owner == OWN_RD_D;
  // Read data passes straight from the RAM in the return cycle and is held afterwards.
  assign i_rdata = i_rvalid ? mem_dout : i_hold;
  assign d_rdata = d_rvalid ? mem_dout : d_hold;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner <= OWN_IDLE;
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      owner <= i_gnt ? OWN_RD_I : (d_gnt && !d_we) ? OWN_RD_D : OWN_IDLE;
      if (i_rvalid) i_hold <= mem_dout;
      if (d_rvalid) d_hold <= mem_dout;
    end
endmodule
